chan_mux_rr: RTL
================

# chan_mux_rr

Registered N-channel stream selector with valid/ready handshake on every input and on the output. It is the parametrised successor to the 4-way 2-bit keyed selector. It adds a round-robin arbitration mode, configurable channel count and data width, and a one-entry output register. It sits between producer channels and a single consumer, e.g. in front of the display/LED datapath.

## Interface
- `NCH`, default 4: number of input channels, ≥2.
- `W`, default 2: data width per channel.
- `SELW`, default `$clog2(NCH)`: select / channel-index width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  NCH*W: channel k occupies bits `[k*W +: W]`.
- `in_valid`  in  NCH: per-channel valid.
- `in_ready`  out  NCH: per-channel ready; at most one bit high per cycle.
- `mode`  in  1: 0 = keyed (select by `sel`), 1 = round-robin.
- `sel`  in  SELW: channel key in keyed mode.
- `out_data`  out  W: registered selected data.
- `out_ch`  out  SELW: index of the channel that produced `out_data`.
- `out_valid`  out  1: output register holds a beat.
- `out_ready`  in  1: consumer accepts the beat.
- `sel_err`  out  1: one-cycle pulse when keyed `sel` ≥ NCH.

## Operation
- Output register has two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Register can load when `can_load = !out_valid | out_ready`.
- Grant, computed combinationally each cycle:
  - Keyed mode: grant channel `sel` iff `sel` < NCH and `in_valid[sel]`; otherwise no grant. This is the default case: the output register is untouched and no `in_ready` is asserted.
  - Round-robin mode: search starts at `(rr_ptr+1) mod NCH` and picks the first channel with `in_valid` set.
- `in_ready[g]` = `can_load` for the granted channel g only; all other bits are 0.
- Transfer on channel g occurs when `in_valid[g] & in_ready[g]`. On transfer:
  - `out_data` ← channel g data, `out_ch` ← g, `out_valid` ← 1.
  - In round-robin mode, `rr_ptr` ← g.
- `rr_ptr` updates only on a round-robin transfer. Keyed transfers leave it unchanged.
- Output handshake completes when `out_valid & out_ready`. With no new transfer that cycle, FULL → EMPTY.
- `mode` and `sel` are sampled every cycle with no internal latching. A change takes effect on the next grant and never disturbs a beat already held in the register.
- `sel_err` pulses (registered) for every cycle in which `mode`=0 and `sel` ≥ NCH. It can only fire when NCH is not a power of two.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_ch`=0, `sel_err`=0.
  - `rr_ptr`=NCH-1, so channel 0 has first priority.
  - `in_ready` is all-zero during reset.
- Latency: an input beat accepted at edge t appears on `out_data` with `out_valid`=1 after edge t (1 cycle).
- Throughput: 1 beat per cycle. When FULL, `out_ready`=1 and a grant exists in the same cycle, the drain and the load happen on the same edge; `out_valid` stays 1.
- Backpressure: FULL with `out_ready`=0 gives `in_ready`=0 on all channels, and `out_data`/`out_ch` stay stable.
- Round-robin wrap: the search wraps from NCH-1 to 0. When only the last-granted channel is valid, it is granted again.
- Reset asserted mid-transfer clears the register asynchronously and drops the held beat. Transfers resume on the first edge after deassertion.
- No combinational path from `out_ready` to `out_data`. `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode` and `sel`.

## Structure
- Shared package `chan_mux_pkg` holds:
  - `MODE_KEYED` = 1'b0 and `MODE_RR` = 1'b1.
  - The function computing `SELW` from NCH.
- Sub-module `rr_arbiter #(NCH)`: combinational. Inputs are request vector and pointer; outputs are one-hot grant, grant index and `any`. It is reused for round-robin mode.
- Top level contains the keyed-grant logic, grant mux, output register, `rr_ptr` and `sel_err`.

## Test plan
- Reset, then keyed mode, `sel`=2, `in_valid`=4'b0100, ch2 data 2'b10, `out_ready`=1 → `in_ready`=4'b0100; next cycle `out_data`=2'b10, `out_ch`=2, `out_valid`=1.
- Keyed `sel`=1 with `in_valid`=4'b1101 → no grant: `in_ready`=0, `out_valid` stays 0.
- Round-robin, all four channels valid continuously, `out_ready`=1 → `out_ch` sequence 0,1,2,3,0,1, one beat per cycle.
- Hold `out_ready`=0 for 3 cycles while FULL → `out_data`/`out_ch` stable and `in_ready`=0. Release → drain and reload on the same edge.
- NCH=3: keyed `sel`=3 → `sel_err` pulses 1 cycle after, no transfer. Assert `rst_n`=0 while FULL → `out_valid`=0 immediately, and after reset the first round-robin grant goes to channel 0.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared definitions for the chan_mux_rr stream selector.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package chan_mux_pkg;

  localparam logic MODE_KEYED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index / select key for nch channels (at least 1 bit).
  function automatic int sel_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping NCH-1 -> 0.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; caller qualifies the grant with its own load condition.
//
// Ports:
//   req     in  NCH   request vector
//   ptr     in  SELW  last-granted channel; search starts at ptr+1
//   gnt     out NCH   one-hot grant (all zero when nothing requests)
//   gnt_idx out SELW  index of the granted channel (0 when none)
//   any     out 1     at least one request granted
module rr_arbiter
  import chan_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = sel_width(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  function automatic int wrap_idx(input int p, input int off);
    return (p + off) % NCH;
  endfunction

  // Offsets 1..NCH visit every channel once, ending on ptr itself, so a lone
  // request from the last-granted channel is granted again.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!any && req[wrap_idx(int'(ptr), i)]) begin
        any                         = 1'b1;
        gnt[wrap_idx(int'(ptr), i)] = 1'b1;
        gnt_idx                     = SELW'(wrap_idx(int'(ptr), i));
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// Registered N-channel stream selector, keyed or round-robin, with a one-entry output register.
// Latency: 1 cycle from input acceptance to out_valid; 1 beat/cycle sustained.
// Backpressure: in_ready is granted only when the output register is empty or draining this cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    NCH channels, channel k at in_data[k*W +: W]
//   in_ready            per-channel ready, at most one bit high
//   mode, sel           0 = keyed by sel, 1 = round-robin
//   out_data/out_ch     registered beat and the channel it came from
//   out_valid/out_ready output handshake
//   sel_err             registered pulse for each keyed cycle with sel >= NCH
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int W    = 2,
  parameter int SELW = sel_width(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic            sel_err_q, sel_err_d;

  logic [NCH-1:0]  rr_gnt, key_gnt, gnt;
  logic [SELW-1:0] rr_idx, gnt_idx;
  logic            rr_any, gnt_any;
  logic [SELW:0]   sel_ext;
  logic            sel_ok;
  logic            can_load;
  logic            xfer;
  logic [W-1:0]    gnt_dat;

  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any     (rr_any)
  );

  // One extra bit keeps the range check meaningful for power-of-two NCH.
  assign sel_ext = {1'b0, sel};
  assign sel_ok  = sel_ext < (SELW+1)'(NCH);

  always_comb begin
    key_gnt = '0;
    for (int k = 0; k < NCH; k++) begin
      key_gnt[k] = (mode == MODE_KEYED) && (sel == SELW'(k)) && in_valid[k];
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end else begin
      gnt     = key_gnt;
      gnt_idx = sel;
      gnt_any = |key_gnt;
    end
  end

  always_comb begin
    gnt_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt[k]) gnt_dat = in_data[k*W +: W];
    end
  end

  assign can_load = !out_valid_q || out_ready;
  // rst_n gating keeps every ready low while the block is held in reset.
  assign in_ready = (rst_n && can_load) ? gnt : '0;
  assign xfer     = gnt_any && can_load;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    sel_err_d   = (mode == MODE_KEYED) && !sel_ok;
    if (xfer) begin
      out_data_d  = gnt_dat;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) rr_ptr_d = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SELW'(NCH-1);
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule
